// File: rtl/spi_reg_ctrl.sv
// Frame/command controller between a byte-level SPI slave and a small register file.
// Decodes the command byte of each CS frame, then issues write/read strobes with auto-increment.
module spi_reg_ctrl #(
  parameter int unsigned ADDR_BITS   = 4,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 CS_i,
  input  logic                 RxDone_i,
  input  logic [7:0]           RxData_i,
  output logic [7:0]           TxData_o,
  output logic                 TxLoad_o,
  output logic [ADDR_BITS-1:0] RegAddr_o,
  output logic [7:0]           RegWrData_o,
  output logic                 RegWrEn_o,
  output logic                 RegRdEn_o,
  input  logic [7:0]           RegRdData_i,
  output logic                 FrameDone_o,
  output logic [7:0]           ByteCount_o
);

  typedef enum logic [2:0] {StIdle, StCmd, StWr, StRdWait, StRd} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 rw_q, rw_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_load_q, tx_load_d;
  logic [ADDR_BITS-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 frame_done_q, frame_done_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic [7:0]           cnt_inc;

  // Bits between the R/W flag and the address field carry no meaning.
  logic unused_rx;
  assign unused_rx = ^RxData_i;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    tx_data_d    = tx_data_q;
    tx_load_d    = 1'b0;
    reg_addr_d   = reg_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    frame_done_d = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    cnt_inc      = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;

    // CS rising ends the frame from any active state; a coincident byte is dropped.
    if (state_q != StIdle && CS_i) begin
      state_d      = StIdle;
      frame_done_d = (byte_cnt_q != 8'd0);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!CS_i) begin
            state_d    = StCmd;
            tx_data_d  = STATUS_BYTE;
            tx_load_d  = 1'b1;
            byte_cnt_d = 8'd0;
          end
        end
        StCmd: begin
          if (RxDone_i) begin
            addr_d     = RxData_i[ADDR_BITS-1:0];
            rw_d       = RxData_i[7];
            byte_cnt_d = cnt_inc;
            if (RxData_i[7]) begin
              reg_addr_d = RxData_i[ADDR_BITS-1:0];
              rd_en_d    = 1'b1;
              state_d    = StRdWait;
            end else begin
              state_d = StWr;
            end
          end
        end
        StWr: begin
          if (RxDone_i) begin
            reg_addr_d = addr_q;
            wr_data_d  = RxData_i;
            wr_en_d    = 1'b1;
            addr_d     = addr_q + ADDR_BITS'(1);
            byte_cnt_d = cnt_inc;
          end
        end
        StRdWait: begin
          tx_data_d = RegRdData_i;
          tx_load_d = 1'b1;
          addr_d    = addr_q + ADDR_BITS'(1);
          state_d   = StRd;
        end
        StRd: begin
          if (RxDone_i) begin
            reg_addr_d = addr_q;
            rd_en_d    = 1'b1;
            byte_cnt_d = cnt_inc;
            state_d    = StRdWait;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      tx_data_q    <= 8'd0;
      tx_load_q    <= 1'b0;
      reg_addr_q   <= '0;
      wr_data_q    <= 8'd0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      byte_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      tx_data_q    <= tx_data_d;
      tx_load_q    <= tx_load_d;
      reg_addr_q   <= reg_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      frame_done_q <= frame_done_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign TxData_o    = tx_data_q;
  assign TxLoad_o    = tx_load_q;
  assign RegAddr_o   = reg_addr_q;
  assign RegWrData_o = wr_data_q;
  assign RegWrEn_o   = wr_en_q;
  assign RegRdEn_o   = rd_en_q;
  assign FrameDone_o = frame_done_q;
  assign ByteCount_o = byte_cnt_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: table of frames driven byte by byte, strobes checked against
// scoreboard queues, plus hand sequences for empty frame, reset mid-read and count saturation.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CS_i;
  logic       RxDone_i;
  logic [7:0] RxData_i;
  logic [7:0] TxData_o;
  logic       TxLoad_o;
  logic [3:0] RegAddr_o;
  logic [7:0] RegWrData_o;
  logic       RegWrEn_o;
  logic       RegRdEn_o;
  logic [7:0] RegRdData_i;
  logic       FrameDone_o;
  logic [7:0] ByteCount_o;

  spi_reg_ctrl #(.ADDR_BITS(4), .STATUS_BYTE(8'hA5)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .CS_i        (CS_i),
    .RxDone_i    (RxDone_i),
    .RxData_i    (RxData_i),
    .TxData_o    (TxData_o),
    .TxLoad_o    (TxLoad_o),
    .RegAddr_o   (RegAddr_o),
    .RegWrData_o (RegWrData_o),
    .RegWrEn_o   (RegWrEn_o),
    .RegRdEn_o   (RegRdEn_o),
    .RegRdData_i (RegRdData_i),
    .FrameDone_o (FrameDone_o),
    .ByteCount_o (ByteCount_o)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;

  logic [11:0] wr_q[$];  // {addr, data}
  logic [3:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_regs [16];

  // Register file stub attached to the DUT; the bench predicts its contents separately.
  logic       init_mem;
  logic [7:0] mem [16];

  function automatic logic [7:0] def_val(input int i);
    if (i == 5) return 8'h5A;
    if (i == 6) return 8'h6B;
    return 8'hC0 | 8'(i);
  endfunction

  always @(posedge Clock) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= def_val(i);
    end else if (RegWrEn_o) begin
      mem[RegAddr_o] <= RegWrData_o;
    end
  end
  assign RegRdData_i = mem[RegAddr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: strobe seen with nothing expected", name);
  endtask

  // Scoreboard side: every strobe pops one prediction.
  always @(negedge Clock) begin
    logic [11:0] w;
    if (RegWrEn_o) begin
      if (wr_q.size() == 0) unexpected("wr_unexp");
      else begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(RegAddr_o), 32'(w[11:8]));
        check("wr_data", 32'(RegWrData_o), 32'(w[7:0]));
      end
    end
    if (RegRdEn_o) begin
      if (rd_q.size() == 0) unexpected("rd_unexp");
      else check("rd_addr", 32'(RegAddr_o), 32'(rd_q.pop_front()));
    end
    if (TxLoad_o) begin
      if (tx_q.size() == 0) unexpected("tx_unexp");
      else check("tx_data", 32'(TxData_o), 32'(tx_q.pop_front()));
    end
    if (FrameDone_o) fd_cnt++;
  end

  typedef struct {
    logic [7:0]  cmd;
    int          ndata;
    logic [23:0] data;       // byte k at data[8k +: 8]
    int          abort_idx;  // byte index on which CS rises, -1 for none
    logic [7:0]  exp_cnt;
    logic        exp_fd;
  } frame_t;

  frame_t vec [8];

  task automatic send_byte(input logic [7:0] b, input logic ew, input logic er);
    RxData_i = b;
    RxDone_i = 1'b1;
    @(negedge Clock);
    RxDone_i = 1'b0;
    check("wr_latency", 32'(RegWrEn_o), 32'(ew));
    check("rd_latency", 32'(RegRdEn_o), 32'(er));
    @(negedge Clock);
    check("tx_latency", 32'(TxLoad_o), 32'(er));
    repeat (3) @(negedge Clock);
  endtask

  task automatic end_checks(input string tag, input int fd0, input logic [7:0] cnt,
                            input logic fd);
    check({tag, "_bytecount"}, 32'(ByteCount_o), 32'(cnt));
    check({tag, "_framedone"}, 32'(fd_cnt - fd0), 32'(fd));
    check({tag, "_pending"}, 32'(wr_q.size() + rd_q.size() + tx_q.size()), 32'd0);
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    int         fd0 = fd_cnt;
    logic [3:0] a = f.cmd[3:0];
    logic       rd = f.cmd[7];
    logic [7:0] b;
    logic       aborted = 1'b0;
    @(negedge Clock);
    CS_i = 1'b0;
    tx_q.push_back(8'hA5);
    repeat (2) @(negedge Clock);
    for (int i = 0; i <= f.ndata; i++) begin
      b = (i == 0) ? f.cmd : f.data[8*(i-1) +: 8];
      if (i == f.abort_idx) begin
        RxData_i = b;
        RxDone_i = 1'b1;
        CS_i     = 1'b1;
        @(negedge Clock);
        RxDone_i = 1'b0;
        check({tag, "_abort_wr"}, 32'(RegWrEn_o), 32'd0);
        check({tag, "_abort_rd"}, 32'(RegRdEn_o), 32'd0);
        aborted = 1'b1;
        break;
      end
      if (rd) begin
        rd_q.push_back(a);
        tx_q.push_back(exp_regs[a]);
        a = a + 4'd1;
      end else if (i > 0) begin
        wr_q.push_back({a, b});
        exp_regs[a] = b;
        a = a + 4'd1;
      end
      send_byte(b, !rd && i > 0, rd);
    end
    if (!aborted) begin
      @(negedge Clock);
      CS_i = 1'b1;
    end
    repeat (3) @(negedge Clock);
    end_checks(tag, fd0, f.exp_cnt, f.exp_fd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    vec[0] = '{cmd: 8'h02, ndata: 3, data: 24'h332211, abort_idx: -1, exp_cnt: 8'd4, exp_fd: 1'b1};
    vec[1] = '{cmd: 8'h85, ndata: 2, data: 24'h000000, abort_idx: -1, exp_cnt: 8'd3, exp_fd: 1'b1};
    vec[2] = '{cmd: 8'h0F, ndata: 2, data: 24'h00BBAA, abort_idx: -1, exp_cnt: 8'd3, exp_fd: 1'b1};
    vec[3] = '{cmd: 8'h01, ndata: 2, data: 24'h008877, abort_idx: 2,  exp_cnt: 8'd2, exp_fd: 1'b1};
    vec[4] = '{cmd: 8'h83, ndata: 0, data: 24'h000000, abort_idx: -1, exp_cnt: 8'd1, exp_fd: 1'b1};
    vec[5] = '{cmd: 8'h07, ndata: 0, data: 24'h000000, abort_idx: -1, exp_cnt: 8'd1, exp_fd: 1'b1};
    vec[6] = '{cmd: 8'h8F, ndata: 1, data: 24'h000000, abort_idx: -1, exp_cnt: 8'd2, exp_fd: 1'b1};
    vec[7] = '{cmd: 8'hF2, ndata: 0, data: 24'h000000, abort_idx: -1, exp_cnt: 8'd1, exp_fd: 1'b1};
    for (int i = 0; i < 16; i++) exp_regs[i] = def_val(i);

    Reset = 1'b0; CS_i = 1'b1; RxDone_i = 1'b0; RxData_i = 8'h00; init_mem = 1'b1;
    repeat (3) @(negedge Clock);
    check("rst_txdata", 32'(TxData_o), 32'd0);
    check("rst_txload", 32'(TxLoad_o), 32'd0);
    check("rst_regaddr", 32'(RegAddr_o), 32'd0);
    check("rst_wrdata", 32'(RegWrData_o), 32'd0);
    check("rst_wren", 32'(RegWrEn_o), 32'd0);
    check("rst_rden", 32'(RegRdEn_o), 32'd0);
    check("rst_framedone", 32'(FrameDone_o), 32'd0);
    check("rst_bytecount", 32'(ByteCount_o), 32'd0);
    Reset = 1'b1; init_mem = 1'b0;
    repeat (2) @(negedge Clock);

    // Idle bytes with CS high must be ignored.
    RxData_i = 8'h03; RxDone_i = 1'b1;
    @(negedge Clock);
    RxDone_i = 1'b0;
    repeat (2) @(negedge Clock);
    check("idle_byte_wren", 32'(RegWrEn_o), 32'd0);
    check("idle_byte_count", 32'(ByteCount_o), 32'd0);

    for (int i = 0; i < 8; i++) run_frame(vec[i], $sformatf("vec%0d", i));

    // Empty frame: status load only, no FrameDone, count cleared.
    fd0 = fd_cnt;
    @(negedge Clock);
    CS_i = 1'b0;
    tx_q.push_back(8'hA5);
    repeat (10) @(negedge Clock);
    CS_i = 1'b1;
    repeat (3) @(negedge Clock);
    end_checks("empty", fd0, 8'd0, 1'b0);

    // Reset while waiting for read data: no load, everything cleared.
    fd0 = fd_cnt;
    CS_i = 1'b0;
    tx_q.push_back(8'hA5);
    repeat (2) @(negedge Clock);
    rd_q.push_back(4'd6);
    RxData_i = 8'h86; RxDone_i = 1'b1;
    @(negedge Clock);
    RxDone_i = 1'b0;
    check("rstmid_rden", 32'(RegRdEn_o), 32'd1);
    Reset = 1'b0; CS_i = 1'b1;
    @(negedge Clock);
    check("rstmid_txload", 32'(TxLoad_o), 32'd0);
    check("rstmid_txdata", 32'(TxData_o), 32'd0);
    check("rstmid_regaddr", 32'(RegAddr_o), 32'd0);
    check("rstmid_rden0", 32'(RegRdEn_o), 32'd0);
    check("rstmid_bytecount", 32'(ByteCount_o), 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    end_checks("rstmid", fd0, 8'd0, 1'b0);
    run_frame('{cmd: 8'h86, ndata: 1, data: 24'h0, abort_idx: -1, exp_cnt: 8'd2, exp_fd: 1'b1},
              "after_rst");

    // Long write frame: byte count saturates at 255, addresses keep wrapping.
    fd0 = fd_cnt;
    @(negedge Clock);
    CS_i = 1'b0;
    tx_q.push_back(8'hA5);
    repeat (2) @(negedge Clock);
    send_byte(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 259; i++) begin
      wr_q.push_back({4'(i), 8'(i)});
      send_byte(8'(i), 1'b1, 1'b0);
    end
    CS_i = 1'b1;
    repeat (3) @(negedge Clock);
    end_checks("saturate", fd0, 8'd255, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
